jtkcpu_muldiv: RTL and testbench

- Parametrised sequential multiply/divide unit for the KCPU ALU; successor to the fixed 8-bit divider.
- Operand width is set by parameter W, with 1 or 2 quotient/product bits per cen tick.
- Covers signed and unsigned multiply (W×W→2W) and divide (2W÷W→W quotient, W remainder).
- Reports overflow and divide-by-zero. The ALU starts it, stalls on busy and captures results on done.

---
 rtl/jtkcpu_muldiv_pkg.sv | 16 +
 rtl/jtkcpu_muldiv_step.sv | 35 +++
 rtl/jtkcpu_muldiv.sv | 201 ++++++++++++++++++++
 tb/tb_jtkcpu_muldiv.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/jtkcpu_muldiv_pkg.sv
// rtl/jtkcpu_muldiv_pkg.sv - shared op encodings and FSM states for the KCPU multiply/divide unit
package jtkcpu_muldiv_pkg;

    localparam logic [1:0] MD_MULU = 2'b00;
    localparam logic [1:0] MD_MULS = 2'b01;
    localparam logic [1:0] MD_DIVU = 2'b10;
    localparam logic [1:0] MD_DIVS = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PREP = 2'd1,
        ST_RUN  = 2'd2,
        ST_FIX  = 2'd3
    } md_state_e;

endpackage

// File: rtl/jtkcpu_muldiv_step.sv
// rtl/jtkcpu_muldiv_step.sv - one combinational shift-add (multiply) or restoring (divide) iteration
module jtkcpu_muldiv_step
    import jtkcpu_muldiv_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         div_i,
    input  logic [W-1:0] m_i,
    input  logic [W-1:0] hi_i,
    input  logic [W-1:0] lo_i,
    output logic [W-1:0] hi_o,
    output logic [W-1:0] lo_o
);

    logic [W:0]   sum;
    logic [W:0]   sh;
    logic [W-1:0] diff;
    logic         ge;

    always_comb begin
        sum  = {1'b0, hi_i} + (lo_i[0] ? {1'b0, m_i} : {(W+1){1'b0}});
        sh   = {hi_i, lo_i[W-1]};
        ge   = sh >= {1'b0, m_i};
        // The true difference is below m_i whenever ge is set, so W bits suffice.
        diff = sh[W-1:0] - m_i;
        if (div_i) begin
            hi_o = ge ? diff : sh[W-1:0];
            lo_o = {lo_i[W-2:0], ge};
        end else begin
            hi_o = sum[W:1];
            lo_o = {sum[0], lo_i[W-1:1]};
        end
    end

endmodule

// File: rtl/jtkcpu_muldiv.sv
// rtl/jtkcpu_muldiv.sv - sequential signed/unsigned multiply (WxW->2W) and divide (2W/W) unit
module jtkcpu_muldiv
    import jtkcpu_muldiv_pkg::*;
#(
    parameter int W      = 16,
    parameter int UNROLL = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cen,
    input  logic           start,
    input  logic [1:0]     op,
    input  logic [2*W-1:0] a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [W-1:0]   rslt,
    output logic [W-1:0]   rslt_hi,
    output logic           v,
    output logic           dz
);

    localparam int STEPS = W / UNROLL;
    localparam int CW    = $clog2(STEPS + 1);

    md_state_e      state_q, state_d;
    logic [1:0]     op_q, op_d;
    logic [2*W-1:0] a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   m_q, m_d;
    logic [W-1:0]   hi_q, hi_d;
    logic [W-1:0]   lo_q, lo_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           neg_q, neg_d;
    logic           rneg_q, rneg_d;
    logic           early_q, early_d;
    logic           done_q, done_d;
    logic [W-1:0]   rslt_q, rslt_d;
    logic [W-1:0]   rslt_hi_q, rslt_hi_d;
    logic           v_q, v_d;
    logic           dz_q, dz_d;

    logic           sa, sb;
    logic [2*W-1:0] a_mag;
    logic [W-1:0]   a_lo_mag;
    logic [W-1:0]   b_mag;
    logic [2*W-1:0] prod_s;
    logic [W-1:0]   q_s, r_s;
    logic           q_ovf;

    logic [W-1:0]   ch_hi [0:UNROLL];
    logic [W-1:0]   ch_lo [0:UNROLL];

    assign ch_hi[0] = hi_q;
    assign ch_lo[0] = lo_q;

    for (genvar gi = 0; gi < UNROLL; gi++) begin : g_step
        jtkcpu_muldiv_step #(.W(W)) u_step (
            .div_i (op_q[1]),
            .m_i   (m_q),
            .hi_i  (ch_hi[gi]),
            .lo_i  (ch_lo[gi]),
            .hi_o  (ch_hi[gi+1]),
            .lo_o  (ch_lo[gi+1])
        );
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        m_d       = m_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        rneg_d    = rneg_q;
        early_d   = early_q;
        done_d    = 1'b0;
        rslt_d    = rslt_q;
        rslt_hi_d = rslt_hi_q;
        v_d       = v_q;
        dz_d      = dz_q;

        // Divide treats a as 2W signed; multiply only looks at the low half.
        sa       = op_q[0] & (op_q[1] ? a_q[2*W-1] : a_q[W-1]);
        sb       = op_q[0] & b_q[W-1];
        a_mag    = sa ? -a_q : a_q;
        a_lo_mag = sa ? -a_q[W-1:0] : a_q[W-1:0];
        b_mag    = sb ? -b_q : b_q;

        prod_s = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
        q_s    = neg_q ? -lo_q : lo_q;
        r_s    = rneg_q ? -hi_q : hi_q;
        // A negative quotient may reach 2^(W-1); a positive one must stay below it.
        q_ovf  = op_q[0] & (neg_q ? (lo_q > {1'b1, {(W-1){1'b0}}}) : lo_q[W-1]);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d    = op;
                    a_d     = a;
                    b_d     = b;
                    state_d = ST_PREP;
                end
            end
            ST_PREP: begin
                neg_d   = sa ^ sb;
                rneg_d  = sa;
                cnt_d   = CW'(STEPS);
                early_d = 1'b0;
                if (op_q[1]) begin
                    m_d  = b_mag;
                    hi_d = a_mag[2*W-1:W];
                    lo_d = a_mag[W-1:0];
                    // A high half not below the divisor cannot yield a W-bit quotient.
                    early_d = (b_q == '0) || (a_mag[2*W-1:W] >= b_mag);
                end else begin
                    m_d  = a_lo_mag;
                    hi_d = '0;
                    lo_d = b_mag;
                end
                state_d = early_d ? ST_FIX : ST_RUN;
            end
            ST_RUN: begin
                hi_d  = ch_hi[UNROLL];
                lo_d  = ch_lo[UNROLL];
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = ST_FIX;
            end
            ST_FIX: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
                if (early_q) begin
                    dz_d      = (b_q == '0);
                    v_d       = 1'b1;
                    rslt_d    = '1;
                    rslt_hi_d = (b_q == '0) ? a_q[W-1:0] : '0;
                end else if (op_q[1]) begin
                    dz_d      = 1'b0;
                    v_d       = q_ovf;
                    rslt_d    = q_s;
                    rslt_hi_d = r_s;
                end else begin
                    dz_d      = 1'b0;
                    v_d       = 1'b0;
                    rslt_d    = prod_s[W-1:0];
                    rslt_hi_d = prod_s[2*W-1:W];
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            m_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            rneg_q    <= 1'b0;
            early_q   <= 1'b0;
            done_q    <= 1'b0;
            rslt_q    <= '0;
            rslt_hi_q <= '0;
            v_q       <= 1'b0;
            dz_q      <= 1'b0;
        end else if (cen) begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            m_q       <= m_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            rneg_q    <= rneg_d;
            early_q   <= early_d;
            done_q    <= done_d;
            rslt_q    <= rslt_d;
            rslt_hi_q <= rslt_hi_d;
            v_q       <= v_d;
            dz_q      <= dz_d;
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;
    assign rslt    = rslt_q;
    assign rslt_hi = rslt_hi_q;
    assign v       = v_q;
    assign dz      = dz_q;

endmodule

// File: tb/tb_jtkcpu_muldiv.sv
// tb/tb_jtkcpu_muldiv.sv - directed self-checking bench for jtkcpu_muldiv (W=16/U=1 and W=32/U=2)
module tb_jtkcpu_muldiv;
    import jtkcpu_muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cen = 1'b1;
    logic        start1 = 1'b0;
    logic        start2 = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a1 = '0;
    logic [15:0] b1 = '0;
    logic [63:0] a2 = '0;
    logic [31:0] b2 = '0;

    logic        busy1, done1, v1, dz1;
    logic [15:0] r1, rh1;
    logic        busy2, done2, v2, dz2;
    logic [31:0] r2, rh2;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit cen3   = 1'b0;
    bit sel    = 1'b0;

    always #5 clk = ~clk;

    jtkcpu_muldiv #(.W(16), .UNROLL(1)) dut16 (
        .clk(clk), .rst(rst), .cen(cen), .start(start1), .op(op), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .rslt(r1), .rslt_hi(rh1), .v(v1), .dz(dz1)
    );

    jtkcpu_muldiv #(.W(32), .UNROLL(2)) dut32 (
        .clk(clk), .rst(rst), .cen(cen), .start(start2), .op(op), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .rslt(r2), .rslt_hi(rh2), .v(v2), .dz(dz2)
    );

    logic        cur_busy, cur_done, cur_v, cur_dz;
    logic [31:0] cur_r, cur_rh;
    assign cur_busy = sel ? busy2 : busy1;
    assign cur_done = sel ? done2 : done1;
    assign cur_v    = sel ? v2 : v1;
    assign cur_dz   = sel ? dz2 : dz1;
    assign cur_r    = sel ? r2 : {16'h0, r1};
    assign cur_rh   = sel ? rh2 : {16'h0, rh1};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(output bit wc);
        cen = cen3 ? (cyc % 3 == 0) : 1'b1;
        @(posedge clk);
        wc = cen;
        #1;
        cyc++;
    endtask

    task automatic do_op(input bit s, input logic [1:0] o, input logic [63:0] av,
                         input logic [31:0] bv, input int exp_ticks,
                         input logic [31:0] exp_r, input logic [31:0] exp_rh,
                         input logic exp_v, input logic exp_dz, input bit poke,
                         input string tag);
        bit wc;
        bit got;
        bit done_seen;
        bit busy_ok;
        int n;
        sel = s;
        op  = o;
        if (s) begin a2 = av; b2 = bv; start2 = 1'b1; end
        else begin a1 = av[31:0]; b1 = bv[15:0]; start1 = 1'b1; end
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick(wc);
            if (wc) got = 1'b1;
        end
        chk({tag, " accept_busy"}, {63'h0, cur_busy}, 64'h1);
        start1 = poke & ~s;
        start2 = poke & s;
        op = ~o;
        a1 = ~a1; b1 = ~b1; a2 = ~a2; b2 = ~b2;
        n = 0; done_seen = 1'b0; busy_ok = 1'b1;
        for (int i = 0; i < 300 && !done_seen; i++) begin
            tick(wc);
            if (wc) n++;
            if (cur_done) done_seen = 1'b1;
            else if (!cur_busy) busy_ok = 1'b0;
        end
        start1 = 1'b0;
        start2 = 1'b0;
        chk({tag, " done_seen"}, {63'h0, done_seen}, 64'h1);
        chk({tag, " latency"}, 64'(n), 64'(exp_ticks));
        chk({tag, " busy_held"}, {63'h0, busy_ok}, 64'h1);
        chk({tag, " busy_at_done"}, {63'h0, cur_busy}, 64'h0);
        chk({tag, " rslt"}, {32'h0, cur_r}, {32'h0, exp_r});
        chk({tag, " rslt_hi"}, {32'h0, cur_rh}, {32'h0, exp_rh});
        chk({tag, " v"}, {63'h0, cur_v}, {63'h0, exp_v});
        chk({tag, " dz"}, {63'h0, cur_dz}, {63'h0, exp_dz});
        for (int i = 0; i < 10; i++) begin
            tick(wc);
            if (!wc) begin
                chk({tag, " done_hold"}, {63'h0, cur_done}, 64'h1);
            end else begin
                chk({tag, " done_clear"}, {63'h0, cur_done}, 64'h0);
                chk({tag, " idle_after"}, {63'h0, cur_busy}, 64'h0);
                break;
            end
        end
    endtask

    initial begin
        bit wc;
        bit stray;
        rst = 1'b1;
        tick(wc);
        tick(wc);
        chk("reset16", {30'h0, busy1, done1, v1, dz1, r1, rh1}, 64'h0);
        chk("reset32", {busy2, done2, v2, dz2, r2[29:0], rh2}, 64'h0);
        rst = 1'b0;
        tick(wc);

        do_op(0, MD_DIVU, 64'h000186A0, 32'h7,    18, 32'h37CD, 32'h0005, 0, 0, 0, "divu");
        do_op(0, MD_DIVS, 64'hFFFFFFF9, 32'h2,    18, 32'hFFFD, 32'hFFFF, 0, 0, 0, "divs_neg_a");
        do_op(0, MD_DIVS, 64'h00000007, 32'hFFFE, 18, 32'hFFFD, 32'h0001, 0, 0, 0, "divs_neg_b");
        do_op(0, MD_DIVS, 64'hFFFF8000, 32'hFFFF, 18, 32'h8000, 32'h0000, 1, 0, 0, "divs_late_ovf");
        do_op(0, MD_DIVS, 64'hFFFF0000, 32'h2,    18, 32'h8000, 32'h0000, 0, 0, 0, "divs_min_q");
        do_op(0, MD_DIVS, 64'hFFFEFFFE, 32'h2,    18, 32'h7FFF, 32'h0000, 1, 0, 0, "divs_neg_ovf");
        do_op(0, MD_DIVU, 64'h00070000, 32'h7,     2, 32'hFFFF, 32'h0000, 1, 0, 0, "divu_early");
        do_op(0, MD_DIVU, 64'h00001234, 32'h0,     2, 32'hFFFF, 32'h1234, 1, 1, 0, "div_zero");
        do_op(0, MD_MULS, 64'h1234FFFD, 32'h5,    18, 32'hFFF1, 32'hFFFF, 0, 0, 0, "muls");
        do_op(0, MD_MULU, 64'h0000FFFF, 32'hFFFF, 18, 32'h0001, 32'hFFFE, 0, 0, 0, "mulu");
        do_op(0, MD_MULU, 64'h00001234, 32'h0100, 18, 32'h3400, 32'h0012, 0, 0, 1, "start_busy");

        do_op(1, MD_MULU, 64'h0000FFFF, 32'h0000FFFF, 18, 32'hFFFE0001, 32'h0, 0, 0, 0, "mulu32");
        do_op(1, MD_MULU, 64'hFFFFFFFF, 32'hFFFFFFFF, 18, 32'h00000001, 32'hFFFFFFFE, 0, 0, 0, "mulu32_max");

        cen3 = 1'b1;
        do_op(0, MD_DIVU, 64'h000186A0, 32'h7, 18, 32'h37CD, 32'h0005, 0, 0, 0, "divu_cen3");
        cen3 = 1'b0;

        sel = 1'b0;
        op = MD_DIVU; a1 = 32'h000186A0; b1 = 16'h7; start1 = 1'b1;
        tick(wc);
        start1 = 1'b0;
        for (int i = 0; i < 5; i++) tick(wc);
        chk("mid_run_busy", {63'h0, busy1}, 64'h1);
        rst = 1'b1;
        tick(wc);
        chk("mid_run_reset", {30'h0, busy1, done1, v1, dz1, r1, rh1}, 64'h0);
        rst = 1'b0;
        stray = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick(wc);
            if (done1 || busy1) stray = 1'b1;
        end
        chk("no_done_after_abort", {63'h0, stray}, 64'h0);
        do_op(0, MD_DIVS, 64'hFFFFFFF9, 32'h2, 18, 32'hFFFD, 32'hFFFF, 0, 0, 0, "after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
